data_select_engine: RTL and testbench

DATA_SELECT_ENGINE -- requirements
Module: data_select_engine

---
 rtl/dsel_pkg.sv | 17 +
 rtl/data_select_engine_if.sv | 47 ++++
 rtl/dsel_fifo.sv | 54 +++++
 rtl/data_select_engine.sv | 109 ++++++++++
 tb/tb_data_select_engine.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dsel_pkg.sv
// Shared types and constants for the data select engine.
// The state encoding and the test-function selectors live here.
package dsel_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD_EVAL  = 3'd1,
    DECIDE     = 3'd2,
    WAIT_SPACE = 3'd3,
    HOLD       = 3'd4
  } state_t;

  localparam int MODE_OR  = 0;
  localparam int MODE_AND = 1;
  localparam int MODE_XOR = 2;

endpackage

// File: rtl/data_select_engine_if.sv
// Request/result bundle for the data select engine.
// rej_cnt is only carried when DSEL_REJECT_CNT_EN is defined.
interface data_select_engine_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] x;
  logic             ready;
  logic             busy;
  logic             reject;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef DSEL_REJECT_CNT_EN
  logic [15:0]      rej_cnt;
`endif

  modport master (
    output start,
    output x,
    output out_ready,
    input  ready,
    input  busy,
    input  reject,
    input  out_valid,
`ifdef DSEL_REJECT_CNT_EN
    input  rej_cnt,
`endif
    input  out_data
  );

  modport slave (
    input  start,
    input  x,
    input  out_ready,
    output ready,
    output busy,
    output reject,
    output out_valid,
`ifdef DSEL_REJECT_CNT_EN
    output rej_cnt,
`endif
    output out_data
  );

endinterface

// File: rtl/dsel_fifo.sv
// Output FIFO with first-word fall-through head.
// Head reads zero while empty so the output is clean after reset.
module dsel_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count
             + (AW+1)'(do_push)
             - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/data_select_engine.sv
// Captures a word, tests its masked bits, queues passing words.
// Optional reject counter: define DSEL_REJECT_CNT_EN.
import dsel_pkg::*;

module data_select_engine #(
  parameter int             WIDTH    = 8,
  parameter int             DEPTH    = 4,
  parameter int             MODE     = 0,
  parameter logic [WIDTH-1:0] SEL_MASK =
    WIDTH'(1) | (WIDTH'(1) << (WIDTH-1))
) (
  input logic                 clk,
  input logic                 rst,
  data_select_engine_if.slave bus
);

  state_t           state;
  state_t           nxt;
  logic [WIDTH-1:0] r;
  logic             s;
  logic [WIDTH-1:0] masked;
  logic             test;
  logic             full;
  logic             empty;
  logic             push;

  assign masked = r & SEL_MASK;

  always_comb begin
    test = |masked;
    if (MODE == MODE_AND)
      test = &(masked | ~SEL_MASK);
    else if (MODE == MODE_XOR)
      test = ^masked;
  end

  // Full is the registered level, so a same-cycle pop cannot unblock.
  assign push = !full &&
                ((state == DECIDE && s) ||
                 (state == WAIT_SPACE));

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:
        if (bus.start) nxt = LOAD_EVAL;
      LOAD_EVAL:
        nxt = DECIDE;
      DECIDE:
        if (!s)        nxt = IDLE;
        else if (full) nxt = WAIT_SPACE;
        else           nxt = HOLD;
      WAIT_SPACE:
        if (!full) nxt = HOLD;
      HOLD:
        if (!bus.start) nxt = IDLE;
      default:
        nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      r     <= '0;
      s     <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && bus.start)
        r <= bus.x;
      if (state == LOAD_EVAL)
        s <= test;
    end
  end

  assign bus.ready  = (state == HOLD);
  assign bus.busy   = (state != IDLE);
  assign bus.reject = (state == DECIDE) && !s;

`ifdef DSEL_REJECT_CNT_EN
  logic [15:0] rej_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rej_q <= '0;
    else if (bus.reject && rej_q != 16'hFFFF)
      rej_q <= rej_q + 16'd1;
  end

  assign bus.rej_cnt = rej_q;
`endif

  dsel_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (bus.out_ready),
    .din   (r),
    .full  (full),
    .empty (empty),
    .head  (bus.out_data)
  );

  assign bus.out_valid = !empty;

endmodule

// File: tb/tb_data_select_engine.sv
// Bench for data_select_engine: directed and random offers
// checked against a queue-based reference model.
module tb_data_select_engine;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  data_select_engine_if #(.WIDTH(8)) if0 ();
  data_select_engine_if #(.WIDTH(8)) if2 ();

  data_select_engine #(
    .WIDTH(8), .DEPTH(4), .MODE(0), .SEL_MASK(8'h81)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0.slave)
  );

  data_select_engine #(
    .WIDTH(8), .DEPTH(4), .MODE(2), .SEL_MASK(8'hFF)
  ) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (if2.slave)
  );

  int         n_chk = 0;
  int         n_fail = 0;
  int         rej_m = 0;
  logic [7:0] q[$];

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic bit accept(int mode, logic [7:0] v,
                                logic [7:0] m);
    if (mode == 0) return (v & m) != 8'h00;
    if (mode == 1) return (v & m) == m;
    return ($countones(v & m) % 2) == 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(string tag);
    chk({tag, "_valid"}, if0.out_valid, q.size() != 0);
    chk({tag, "_data"}, if0.out_data,
        q.size() != 0 ? q[0] : 8'h00);
  endtask

  // One full request on dut0; the FIFO must have space.
  task automatic offer0(logic [7:0] v);
    bit a;
    a = accept(0, v, 8'h81);
    if0.x = v;
    if0.start = 1'b1;
    step();
    chk("busy_load", if0.busy, 1);
    if0.x = ~v;
    step();
    if0.start = 1'b0;
    chk("reject_decide", if0.reject, !a);
    chk("ready_decide", if0.ready, 0);
    step();
    if (a) begin
      chk("ready_hold", if0.ready, 1);
      q.push_back(v);
    end else begin
      chk("idle_after_rej", if0.busy, 0);
      if (rej_m < 65535) rej_m++;
    end
    chk("reject_clear", if0.reject, 0);
    chk_head("offer_head");
    step();
    chk("idle", if0.busy, 0);
`ifdef DSEL_REJECT_CNT_EN
    chk("rej_cnt", if0.rej_cnt, rej_m);
`endif
  endtask

  task automatic pop0();
    if (q.size() == 0) begin
      if0.out_ready = 1'b1;
      step();
      if0.out_ready = 1'b0;
      chk_head("pop_empty");
    end else begin
      chk_head("pre_pop");
      if0.out_ready = 1'b1;
      step();
      if0.out_ready = 1'b0;
      void'(q.pop_front());
      chk_head("post_pop");
    end
  endtask

  initial begin
    logic [7:0] v;
    rst = 1'b1;
    if0.start = 1'b0; if0.x = '0; if0.out_ready = 1'b0;
    if2.start = 1'b0; if2.x = '0; if2.out_ready = 1'b0;
    #1;
    chk("rst_ready", if0.ready, 0);
    chk("rst_busy", if0.busy, 0);
    chk("rst_reject", if0.reject, 0);
    chk("rst_valid", if0.out_valid, 0);
    chk("rst_data", if0.out_data, 0);
    repeat (2) step();
    rst = 1'b0;
    step();

    // Basic accept with start held, then released.
    if0.x = 8'h80;
    if0.start = 1'b1;
    step();
    chk("lat_e0_busy", if0.busy, 1);
    chk("lat_e0_ready", if0.ready, 0);
    step();
    chk("lat_e1_ready", if0.ready, 0);
    step();
    chk("lat_e2_ready", if0.ready, 1);
    chk("lat_e2_valid", if0.out_valid, 1);
    chk("lat_e2_data", if0.out_data, 8'h80);
    if0.x = 8'h55;
    step();
    chk("hold_ready", if0.ready, 1);
    chk("hold_data", if0.out_data, 8'h80);
    if0.start = 1'b0;
    step();
    chk("drop_ready", if0.ready, 0);
    chk("drop_busy", if0.busy, 0);
    q.push_back(8'h80);
    pop0();
    pop0();

    offer0(8'h3C);

    // Parity mode on the second instance.
    if2.x = 8'h07;
    if2.start = 1'b1;
    step();
    if2.start = 1'b0;
    step();
    chk("xor07_rej", if2.reject, !accept(2, 8'h07, 8'hFF));
    step();
    chk("xor07_ready", if2.ready, 1);
    chk("xor07_data", if2.out_data, 8'h07);
    step();
    chk("xor07_idle", if2.busy, 0);
    if2.x = 8'h03;
    if2.start = 1'b1;
    step();
    if2.start = 1'b0;
    step();
    chk("xor03_rej", if2.reject, !accept(2, 8'h03, 8'hFF));
    step();
    chk("xor03_idle", if2.busy, 0);
    chk("xor03_data", if2.out_data, 8'h07);

    // Random offers with random pops.
    repeat (24) begin
      v = 8'($urandom);
      if (q.size() == 4 || $urandom_range(0, 2) == 0)
        pop0();
      if (q.size() < 4)
        offer0(v);
    end
    while (q.size() != 0) pop0();
    pop0();

    // Fill the FIFO and stall the fifth word.
    offer0(8'h01);
    offer0(8'h81);
    offer0(8'h80);
    offer0(8'hFF);
    if0.x = 8'h11;
    if0.start = 1'b1;
    repeat (3) step();
    chk("ws_busy", if0.busy, 1);
    chk("ws_ready", if0.ready, 0);
    step();
    chk("ws2_ready", if0.ready, 0);
    if0.out_ready = 1'b1;
    step();
    if0.out_ready = 1'b0;
    void'(q.pop_front());
    chk("ws_pop_ready", if0.ready, 0);
    chk("ws_pop_busy", if0.busy, 1);
    chk_head("ws_pop");
    step();
    chk("ws_hold", if0.ready, 1);
    q.push_back(8'h11);
    if0.start = 1'b0;
    step();
    chk("ws_idle", if0.busy, 0);
    while (q.size() != 0) pop0();

    // Push and pop together at count 2.
    offer0(8'h01);
    offer0(8'h80);
    if0.x = 8'h81;
    if0.start = 1'b1;
    step();
    step();
    if0.start = 1'b0;
    if0.out_ready = 1'b1;
    step();
    if0.out_ready = 1'b0;
    void'(q.pop_front());
    q.push_back(8'h81);
    chk("pp_ready", if0.ready, 1);
    chk_head("pp");
    step();
    while (q.size() != 0) pop0();
    pop0();

    // Reset during LOAD_EVAL with two words queued.
    offer0(8'h01);
    offer0(8'hFF);
    if0.x = 8'h81;
    if0.start = 1'b1;
    step();
    chk("mid_busy", if0.busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", if0.busy, 0);
    chk("mid_rst_valid", if0.out_valid, 0);
    chk("mid_rst_data", if0.out_data, 0);
    if0.start = 1'b0;
    #4;
    rst = 1'b0;
    q.delete();
    rej_m = 0;
    repeat (3) step();
    chk("post_rst_valid", if0.out_valid, 0);
    chk("post_rst_busy", if0.busy, 0);
`ifdef DSEL_REJECT_CNT_EN
    chk("post_rst_rej", if0.rej_cnt, 0);
`endif
    offer0(8'h3C);
    offer0(8'h81);
    pop0();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
